// File: rtl/skylark_mem_pkg.sv
// Shared types and default widths for the Skylark data-memory arbiter.
package skylark_mem_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_STARVE_MAX = 8;
    // Counter width covers the full legal STARVE_MAX range of 1..255.
    localparam int STARVE_CNT_W   = 8;

    typedef enum logic [1:0] {
        ARB,
        CORE_RD,
        HOST_RD
    } arb_state_t;

    typedef enum logic [1:0] {
        W_NONE,
        W_CORE,
        W_HOST
    } winner_t;

endpackage

// File: rtl/skylark_starve_ctr.sv
// Saturating count of consecutive host arbitration losses; sat_o forces a host win.
module skylark_starve_ctr
    import skylark_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [STARVE_CNT_W-1:0] SAT_VAL = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == SAT_VAL);

    // Clear takes priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/skylark_dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core W-stage port and the host port.
// Outputs are Mealy: combinational from the state register and the current inputs.
module skylark_dmem_arbiter
    import skylark_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_lock,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q;
    winner_t    winner;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

    // Host wins outright under lock or starvation; otherwise core has priority.
    always_comb begin
        winner = W_NONE;
        if (host_valid && (host_lock || starve_sat)) begin
            winner = W_HOST;
        end else if (core_req && !host_lock) begin
            winner = W_CORE;
        end else if (host_valid) begin
            winner = W_HOST;
        end
    end

    assign starve_inc = (state_q == ARB) && host_valid && (winner != W_HOST);
    assign starve_clr = !host_valid || ((state_q == ARB) && (winner == W_HOST));

    skylark_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk_i (clk),
        .rst_ni(reset),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (winner == W_CORE && !core_we) begin
                        state_q <= CORE_RD;
                    end else if (winner == W_HOST && !host_we) begin
                        state_q <= HOST_RD;
                    end else begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Everything is held at 0 while reset is low, so an in-flight host read never reports.
    always_comb begin
        core_rdata  = '0;
        core_stall  = 1'b0;
        host_ready  = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (reset) begin
            case (state_q)
                ARB: begin
                    case (winner)
                        W_CORE: begin
                            mem_en     = 1'b1;
                            mem_we     = core_we;
                            mem_addr   = core_addr;
                            mem_wdata  = core_wdata;
                            core_stall = !core_we;
                        end
                        W_HOST: begin
                            host_ready = 1'b1;
                            mem_en     = 1'b1;
                            mem_we     = host_we;
                            mem_addr   = host_addr;
                            mem_wdata  = host_wdata;
                            core_stall = core_req;
                        end
                        default: core_stall = core_req;
                    endcase
                end
                CORE_RD: begin
                    core_rdata = mem_rdata;
                end
                HOST_RD: begin
                    host_rvalid = 1'b1;
                    host_rdata  = mem_rdata;
                    core_stall  = core_req;
                end
                default: begin
                    core_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skylark_dmem_arbiter.sv
// Bench for skylark_dmem_arbiter: vector table with a read-data scoreboard, plus starvation and reset sequences.
module tb_skylark_dmem_arbiter;

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        lock;
        logic        hval;
        logic        hwe;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        e_stall;
        logic        e_men;
        logic        e_mwe;
        logic        e_hready;
        logic [31:0] e_maddr;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        bit          is_host;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, host_lock, host_valid, host_we;
    logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
    logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        core_stall, host_ready, host_rvalid, mem_en, mem_we;

    logic [31:0] ram [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    skylark_dmem_arbiter #(
        .DATA_W(32),
        .ADDR_W(32),
        .STARVE_MAX(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_lock  (host_lock),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous-read RAM model; preload values are installed while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            ram[8'h08] <= 32'h12345678;
            ram[8'h0C] <= 32'hA5A50030;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [31:0] caddr,
                                input logic [31:0] cwdata, input logic lock, input logic hval,
                                input logic hwe, input logic [31:0] haddr, input logic [31:0] hwdata,
                                input logic e_stall, input logic e_men, input logic e_mwe,
                                input logic e_hready, input logic [31:0] e_maddr, input logic [31:0] e_rd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.lock = lock; v.hval = hval; v.hwe = hwe; v.haddr = haddr; v.hwdata = hwdata;
        v.e_stall = e_stall; v.e_men = e_men; v.e_mwe = e_mwe; v.e_hready = e_hready;
        v.e_maddr = e_maddr; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic drive_idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_lock = 0; host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " core_stall"}, 32'(core_stall), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " host_ready"}, 32'(host_ready), 0);
        chk({tag, " host_rvalid"}, 32'(host_rvalid), 0);
        chk({tag, " host_rdata"}, host_rdata, 0);
        chk({tag, " core_rdata"}, core_rdata, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive_idle();
        core_req = 1; host_valid = 1; host_lock = 1; core_addr = 32'h10; host_addr = 32'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();

        // creq cwe caddr cwdata lock hval hwe haddr hwdata | stall men mwe hready maddr rd
        vecs.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,0,          0,1,1,0,32'h10,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h10,0,            0,0,0,0,0,          1,1,0,0,32'h10,32'hDEADBEEF));
        vecs.push_back(mk(1,0,32'h10,0,            0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,0,32'h20,0,     0,1,0,1,32'h20,32'h12345678));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h20,0,            0,0,0,0,0,          1,1,0,0,32'h20,32'h12345678));
        vecs.push_back(mk(1,0,32'h20,0,            0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h10,0,            0,0,0,0,0,          1,1,0,0,32'h10,32'hDEADBEEF));
        vecs.push_back(mk(1,0,32'h10,0,            0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h30,0,            1,1,1,32'h0,32'h100, 1,1,1,1,32'h0,0));
        vecs.push_back(mk(1,0,32'h30,0,            1,1,1,32'h4,32'h104, 1,1,1,1,32'h4,0));
        vecs.push_back(mk(1,0,32'h30,0,            1,1,1,32'h8,32'h108, 1,1,1,1,32'h8,0));
        vecs.push_back(mk(1,0,32'h30,0,            1,1,1,32'hC,32'h10C, 1,1,1,1,32'hC,0));
        vecs.push_back(mk(1,0,32'h30,0,            1,0,0,0,0,          1,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h30,0,            0,0,0,0,0,          1,1,0,0,32'h30,32'hA5A50030));
        vecs.push_back(mk(1,0,32'h30,0,            0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,0,32'h8,0,      0,1,0,1,32'h8,32'h108));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h10,0,            0,1,0,32'h20,0,     1,1,0,0,32'h10,32'hDEADBEEF));
        vecs.push_back(mk(1,0,32'h10,0,            0,1,0,32'h20,0,     0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,0,32'h20,0,     0,1,0,1,32'h20,32'h12345678));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,0,          0,0,0,0,0,0));

        foreach (vecs[i]) begin
            vec_t v;
            sb_t  e;
            v = vecs[i];
            core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwdata;
            host_lock = v.lock; host_valid = v.hval; host_we = v.hwe;
            host_addr = v.haddr; host_wdata = v.hwdata;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_host) begin
                    chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 1);
                    chk($sformatf("v%0d host_rdata", i), host_rdata, e.data);
                    chk($sformatf("v%0d core_rdata", i), core_rdata, 0);
                end else begin
                    chk($sformatf("v%0d core_rdata", i), core_rdata, e.data);
                    chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 0);
                end
            end else begin
                chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 0);
                chk($sformatf("v%0d core_rdata", i), core_rdata, 0);
                chk($sformatf("v%0d host_rdata", i), host_rdata, 0);
            end
            chk($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(v.e_stall));
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v.e_men));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.e_mwe));
            chk($sformatf("v%0d host_ready", i), 32'(host_ready), 32'(v.e_hready));
            chk($sformatf("v%0d mem_addr", i), mem_addr, v.e_maddr);
            if (v.e_men && !v.e_mwe) sb.push_back('{v.e_hready, v.e_rd});
            @(posedge clk); #1;
        end

        // Starvation: host wins only on every ninth ARB cycle under continuous core stores.
        for (int k = 0; k < 18; k++) begin
            logic hwin;
            hwin = (k == 8) || (k == 17);
            core_req = 1; core_we = 1; core_addr = 32'h40 + 32'(4 * k); core_wdata = 32'(k);
            host_lock = 0; host_valid = 1; host_we = 1; host_addr = 32'h80; host_wdata = 32'h77;
            @(negedge clk);
            chk($sformatf("starve%0d host_ready", k), 32'(host_ready), 32'(hwin));
            chk($sformatf("starve%0d core_stall", k), 32'(core_stall), 32'(hwin));
            chk($sformatf("starve%0d mem_we", k), 32'(mem_we), 1);
            chk($sformatf("starve%0d mem_addr", k), mem_addr, hwin ? 32'h80 : 32'h40 + 32'(4 * k));
            chk($sformatf("starve%0d mem_wdata", k), mem_wdata, hwin ? 32'h77 : 32'(k));
            @(posedge clk); #1;
        end

        // Reset during HOST_RD discards the read.
        drive_idle();
        host_valid = 1; host_addr = 32'h20;
        @(negedge clk);
        chk("rst_rd host_ready", 32'(host_ready), 1);
        @(posedge clk); #1;
        host_valid = 0; core_req = 1; core_addr = 32'h10;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        check_all_zero("rst_mid2");
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();
        core_req = 1; core_addr = 32'h10;
        @(negedge clk);
        chk("post_rst core mem_en", 32'(mem_en), 1);
        chk("post_rst core_stall", 32'(core_stall), 1);
        chk("post_rst host_rvalid", 32'(host_rvalid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst core_rdata", core_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_idle();
        host_valid = 1; host_addr = 32'h20;
        @(negedge clk);
        chk("fresh host_ready", 32'(host_ready), 1);
        @(posedge clk); #1;
        host_valid = 0;
        @(negedge clk);
        chk("fresh host_rvalid", 32'(host_rvalid), 1);
        chk("fresh host_rdata", host_rdata, 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh rvalid drop", 32'(host_rvalid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/skylark_dmem_arbiter.md
# skylark_dmem_arbiter

Shares the single-port, synchronous-read data RAM between the Skylark core's Writeback-stage load/store port and an external host port used for program/weight loading and debug readback. It sits between `skylark_core` (MemWriteW/ALUResultW/WriteData/ReadData) and the data RAM. Core accesses win by default. A host starvation limit and a host lock input guarantee host progress. The block drives `core_stall` into the core's stall logic.

## Interface
- `DATA_W`, 32: data width of all data buses.
- `ADDR_W`, 32: address width; byte addresses passed through unmodified.
- `STARVE_MAX`, 8: consecutive lost host arbitration cycles before the host is forced to win; legal range 1..255.

- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `core_req`  input  1  core W-stage memory access present (load or store).
- `core_we`  input  1  1 = store (MemWriteW), 0 = load.
- `core_addr`  input  ADDR_W  access address (ALUResultW).
- `core_wdata`  input  DATA_W  store data (WriteData).
- `core_rdata`  output  DATA_W  load data (ReadData); 0 when not returning core data.
- `core_stall`  output  1  holds the core pipeline (ORed into StallF/D/E/W).
- `host_lock`  input  1  host owns the RAM exclusively; core stalled on any request.
- `host_valid`  input  1  host request valid.
- `host_ready`  output  1  host request accepted this cycle.
- `host_we`, `host_addr`, `host_wdata`  input  1/ADDR_W/DATA_W  host request fields; stable while valid && !ready.
- `host_rvalid`  output  1  one-cycle pulse, host read data valid.
- `host_rdata`  output  DATA_W  host read data; 0 when host_rvalid = 0.
- `mem_en`, `mem_we`  output  1/1  RAM enable / write enable.
- `mem_addr`, `mem_wdata`  output  ADDR_W/DATA_W  RAM address / write data.
- `mem_rdata`  input  DATA_W  RAM read data, valid the cycle after a read issue.

## Operation
- FSM states: ARB, CORE_RD, HOST_RD. Reset state ARB; starvation counter 0.
- ARB: winner = host if host_valid && (host_lock || starve_cnt == STARVE_MAX); else core if core_req && !host_lock; else host if host_valid; else none.
- Core write granted: mem_en=mem_we=1, core_stall=0; stay ARB.
- Core read granted: mem_en=1, mem_we=0, core_stall=1; go CORE_RD.
- Host granted: host_ready=1, mem driven from host fields. Write: stay ARB. Read: go HOST_RD.
- core_req && core loses arbitration: core_stall=1.
- CORE_RD: mem_en=0, core_rdata=mem_rdata, core_stall=0; the core advances at the cycle end. Next state ARB, with core_req ignored this cycle.
- HOST_RD: mem_en=0, host_rvalid=1, host_rdata=mem_rdata, host_ready=0. A core_req this cycle gets core_stall=1. Next state ARB.
- Starvation counter: in ARB, increments (saturating at STARVE_MAX) when host_valid && host not granted. Clears on host grant, and when host_valid=0.
- host_lock rising mid-CORE_RD: the core read completes normally; the lock takes effect from the next ARB cycle.
- Reset asserted in any state: immediate return to ARB, counter 0. All outputs 0 while reset is low, including core_stall. Partial host reads are discarded with no host_rvalid.

## Timing
- Outputs are combinational from state and inputs (Mealy); the RAM read latency is exactly 1 cycle.
- Core store: 0 added cycles if it wins. Core load: 1 stall cycle, data in the second cycle.
- Host write: accepted in the grant cycle. Host read: host_rvalid exactly 1 cycle after the host_ready cycle.
- Worst-case host wait with a continuous core_req: STARVE_MAX + 1 ARB cycles (plus at most one CORE_RD cycle).
- Back-to-back core loads: 2 cycles each, with no idle cycle between them.

## Structure
- Package `skylark_mem_pkg`: `arb_state_t` enum {ARB, CORE_RD, HOST_RD}, `winner_t` enum {W_NONE, W_CORE, W_HOST}, default width constants.
- Sub-module `skylark_starve_ctr`: saturating counter with inc/clr/sat, parameterised by STARVE_MAX. The arbiter FSM and mux logic live in the top module.

## Test plan
- Core store only, addr 0x10 data 0xDEADBEEF: mem_en=mem_we=1 same cycle, core_stall never 1; a later core load of 0x10 returns 0xDEADBEEF in the second cycle, with core_stall=1 for exactly one cycle.
- Host read of 0x20 (preloaded 0x12345678), core idle: host_ready in cycle 0, host_rvalid=1 with rdata 0x12345678 in cycle 1 only.
- Continuous core stores plus host_valid held (STARVE_MAX=8): host loses 8 cycles, then wins on the 9th ARB cycle with core_stall=1 that cycle; counter returns to 0.
- host_lock=1 with core_req load pending: core_stall held at 1 and core gets no mem_en. Host writes 0x0..0xC proceed 1 per cycle. After lock drops, the core load completes in 2 cycles.
- Simultaneous core load and host read, counter 0: core wins (CORE_RD), host_ready asserted in the following ARB cycle, host_rvalid one cycle after that.
- Reset asserted during HOST_RD: all outputs 0 immediately, no host_rvalid. After release the state is ARB and the counter is 0; a fresh host read completes normally.
